// File: rtl/f_fetch_unit_pkg.sv
// Shared constants, state encoding and F/D register layout for the F-stage fetch unit.
package f_fetch_unit_pkg;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC   = 32'h0000_4180;
   localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
   localparam logic [31:0] IMEM_HI  = 32'h0000_6FFF;
   localparam logic [4:0]  EXC_ADEL = 5'd4;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_HELD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  exccode;
      logic        bd;
   } fd_t;
endpackage

// File: rtl/f_fetch_unit_fd_reg.sv
// F/D pipeline register: load on enable, synchronous flush to the handler entry, async clear.
module fd_reg
   import f_fetch_unit_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic flush,
   input  fd_t  d,
   output fd_t  q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (flush) begin
         q.pc      <= EXC_PC;
         q.instr   <= '0;
         q.exccode <= '0;
         q.bd      <= 1'b0;
      end else if (en) begin
         q <= d;
      end
   end
endmodule

// File: rtl/f_fetch_unit.sv
// F-stage fetch: PC register, imem handshake, AdEL detection, stall buffering and
// exception redirect with drain of an in-flight response.
module f_fetch_unit
   import f_fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] npc,
   input  logic        stall,
   input  logic        req,
   input  logic        d_eret,
   input  logic        d_is_jump,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] f_pc,
   output logic        f_wait,
   output logic [31:0] fd_pc,
   output logic [31:0] fd_instr,
   output logic [4:0]  fd_exccode,
   output logic        fd_bd
);
   state_t      state, state_nxt;
   logic [31:0] pc_q, pc_nxt;
   logic [31:0] buf_q, buf_nxt;
   logic [31:0] redir_q, redir_nxt;
   logic        adel, complete;
   logic [31:0] word;
   fd_t         fd_d, fd_q;

   assign adel = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_REQ;
         pc_q    <= RESET_PC;
         buf_q   <= '0;
         redir_q <= '0;
      end else begin
         state   <= state_nxt;
         pc_q    <= pc_nxt;
         buf_q   <= buf_nxt;
         redir_q <= redir_nxt;
      end
   end

   always_comb begin
      imem_req  = 1'b0;
      f_wait    = 1'b0;
      complete  = 1'b0;
      state_nxt = state;
      pc_nxt    = pc_q;
      buf_nxt   = buf_q;
      redir_nxt = redir_q;
      case (state)
         S_REQ: begin
            imem_req = !adel;
            f_wait   = !imem_rvalid && !adel;
            complete = imem_rvalid || adel;
         end
         S_HELD:  complete = 1'b1;
         S_DRAIN: begin
            imem_req = 1'b1;
            f_wait   = 1'b1;
         end
         default: state_nxt = S_REQ;
      endcase

      if (req) begin
         buf_nxt = '0;
         // A response still owed by memory must be swallowed before the redirect PC is fetched.
         if (f_wait && !(state == S_DRAIN && imem_rvalid)) begin
            state_nxt = S_DRAIN;
            redir_nxt = EXC_PC;
         end else begin
            pc_nxt    = EXC_PC;
            state_nxt = S_REQ;
         end
      end else if (state == S_DRAIN) begin
         if (imem_rvalid) begin
            pc_nxt    = redir_q;
            state_nxt = S_REQ;
         end
      end else if (complete) begin
         if (stall) begin
            state_nxt = S_HELD;
            if (state == S_REQ) buf_nxt = adel ? '0 : imem_rdata;
         end else begin
            pc_nxt    = npc;
            state_nxt = S_REQ;
         end
      end
   end

   assign word = (state == S_HELD) ? buf_q : imem_rdata;

   always_comb begin
      fd_d.pc      = pc_q;
      fd_d.instr   = (d_eret || adel) ? '0 : word;
      fd_d.exccode = adel ? EXC_ADEL : '0;
      fd_d.bd      = d_is_jump;
   end

   fd_reg u_fd_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (complete && !stall),
      .flush (req),
      .d     (fd_d),
      .q     (fd_q)
   );

   assign imem_addr  = pc_q;
   assign f_pc       = pc_q;
   assign fd_pc      = fd_q.pc;
   assign fd_instr   = fd_q.instr;
   assign fd_exccode = fd_q.exccode;
   assign fd_bd      = fd_q.bd;
endmodule

// File: tb/tb_f_fetch_unit.sv
// Randomized bench for f_fetch_unit against a cycle-level behavioural model of the fetch stage.
module tb_f_fetch_unit;
   localparam logic [31:0] T_RESET = 32'h0000_3000;
   localparam logic [31:0] T_EXC   = 32'h0000_4180;
   localparam logic [31:0] T_LO    = 32'h0000_3000;
   localparam logic [31:0] T_HI    = 32'h0000_6FFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] npc;
   logic        stall, req, d_eret, d_is_jump;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] f_pc;
   logic        f_wait;
   logic [31:0] fd_pc, fd_instr;
   logic [4:0]  fd_exccode;
   logic        fd_bd;

   f_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .npc(npc), .stall(stall), .req(req),
      .d_eret(d_eret), .d_is_jump(d_is_jump),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .f_pc(f_pc), .f_wait(f_wait),
      .fd_pc(fd_pc), .fd_instr(fd_instr), .fd_exccode(fd_exccode), .fd_bd(fd_bd)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   // Instruction memory contents as a pure function of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Model: architectural PC, expected F/D contents, and whether F is parked or draining.
   logic [31:0] m_pc, m_fd_pc, m_fd_instr;
   logic [4:0]  m_fd_exc;
   logic        m_fd_bd;
   bit          m_held, m_drain;
   bit          bad, exp_req, exp_wait, done, pending;
   bit          mem_busy;
   int          lat;

   initial begin
      rst_n = 1'b0; npc = '0; stall = 1'b0; req = 1'b0; d_eret = 1'b0; d_is_jump = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0;
      mem_busy = 0; lat = 0;
      #12;
      check("reset_f_pc", f_pc, T_RESET);
      check("reset_fd_pc", fd_pc, 32'h0);
      check("reset_fd_instr", fd_instr, 32'h0);
      check("reset_fd_exccode", 32'(fd_exccode), 32'h0);
      check("reset_fd_bd", 32'(fd_bd), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      m_pc = T_RESET; m_fd_pc = '0; m_fd_instr = '0; m_fd_exc = '0; m_fd_bd = 1'b0;
      m_held = 0; m_drain = 0;

      repeat (3000) begin
         bad     = (m_pc[1:0] != 2'b00) || (m_pc < T_LO) || (m_pc > T_HI);
         exp_req = m_drain || (!m_held && !bad);
         check("imem_req", 32'(imem_req), 32'(exp_req));
         if (exp_req) check("imem_addr", imem_addr, m_pc);
         check("f_pc", f_pc, m_pc);
         check("fd_pc", fd_pc, m_fd_pc);
         check("fd_instr", fd_instr, m_fd_instr);
         check("fd_exccode", 32'(fd_exccode), 32'(m_fd_exc));
         check("fd_bd", 32'(fd_bd), 32'(m_fd_bd));

         stall     = ($urandom_range(0, 3) == 0);
         req       = ($urandom_range(0, 19) == 0);
         d_eret    = ($urandom_range(0, 7) == 0);
         d_is_jump = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 15))
            0:       npc = m_pc + 32'd2;
            1:       npc = 32'h0000_7000;
            2:       npc = 32'h0000_2FFC;
            3, 4:    npc = T_LO + ($urandom_range(0, 4095) << 2);
            default: npc = m_pc + 32'd4;
         endcase

         // Memory responder with 0..3 cycles of latency per request.
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (imem_req) begin
            if (!mem_busy) begin
               lat = $urandom_range(0, 3);
               mem_busy = 1;
            end
            if (lat == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(imem_addr);
               mem_busy    = 0;
            end else begin
               lat--;
            end
         end else begin
            mem_busy = 0;
         end
         #1;

         pending  = m_drain ? !imem_rvalid : (!m_held && !bad && !imem_rvalid);
         exp_wait = m_drain || pending;
         check("f_wait", 32'(f_wait), 32'(exp_wait));
         done = !m_drain && (m_held || bad || imem_rvalid);

         if (req) begin
            m_fd_pc = T_EXC; m_fd_instr = '0; m_fd_exc = '0; m_fd_bd = 1'b0;
            m_held = 0;
            if (pending) m_drain = 1;
            else begin
               m_drain = 0;
               m_pc = T_EXC;
            end
         end else if (m_drain) begin
            if (imem_rvalid) begin
               m_drain = 0;
               m_pc = T_EXC;
            end
         end else if (done) begin
            if (stall) m_held = 1;
            else begin
               m_fd_pc    = m_pc;
               m_fd_instr = (d_eret || bad) ? 32'h0 : mem_word(m_pc);
               m_fd_exc   = bad ? 5'd4 : 5'd0;
               m_fd_bd    = d_is_jump;
               m_pc       = npc;
               m_held     = 0;
            end
         end
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
